// File: rtl/approx_mul_accumulator.sv
// Frame accumulator for approximate-multiplier products.
// Sums a product stream per frame and presents sum, term count and overflow.
module approx_mul_accumulator #(
    parameter int  ACC_W     = 24,
    parameter int  MAX_TERMS = 256,
    parameter bit  SAT       = 1'b1,
    localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [15:0]      prod_data,
    input  logic             prod_last,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_data,
    output logic [CNT_W-1:0] acc_count,
    output logic             acc_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             rdy_q, rdy_d;

    logic             accept;
    logic             carry;
    logic             close;
    logic [ACC_W:0]   ext;
    logic [CNT_W-1:0] cnt_inc;

    assign accept  = prod_valid & rdy_q;
    assign ext     = {1'b0, sum_q} + {{(ACC_W - 15){1'b0}}, prod_data};
    assign carry   = ext[ACC_W];
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign close   = prod_last | (cnt_inc == CNT_W'(MAX_TERMS));

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | carry;
                    // Saturation sticks: all-ones plus anything nonzero carries again
                    if (carry && SAT) begin
                        sum_d = {ACC_W{1'b1}};
                    end else begin
                        sum_d = ext[ACC_W-1:0];
                    end
                    state_d = close ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (acc_ready) begin
                    state_d = IDLE;
                    sum_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdy_d = (state_d != HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
        end
    end

    assign prod_ready = rdy_q;
    assign acc_valid  = (state_q == HOLD);
    assign acc_data   = sum_q;
    assign acc_count  = cnt_q;
    assign acc_ovf    = ovf_q;

endmodule

// File: tb/tb_approx_mul_accumulator.sv
// Scoreboard bench for approx_mul_accumulator across four parameter sets.
// Instance 0: 24b/256/sat, 1: 17b/256/sat, 2: 17b/256/wrap, 3: 24b/4/sat.
module tb_approx_mul_accumulator;

    typedef struct packed {
        logic [23:0] d;
        logic [8:0]  c;
        logic        o;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        pv [4];
    logic        pl [4];
    logic [15:0] pd [4];
    logic        ar [4];
    logic        pr [4];
    logic        av [4];
    logic        ao [4];

    logic [23:0] ad0, ad3;
    logic [16:0] ad1, ad2;
    logic [8:0]  ac0, ac1, ac2;
    logic [2:0]  ac3;

    int checks;
    int errors;

    res_t    q [$];
    longint  msum [4];
    int      mcnt [4];
    bit      movf [4];

    approx_mul_accumulator #(.ACC_W(24), .MAX_TERMS(256), .SAT(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .prod_valid(pv[0]), .prod_ready(pr[0]), .prod_data(pd[0]), .prod_last(pl[0]),
        .acc_valid(av[0]), .acc_ready(ar[0]),
        .acc_data(ad0), .acc_count(ac0), .acc_ovf(ao[0])
    );

    approx_mul_accumulator #(.ACC_W(17), .MAX_TERMS(256), .SAT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .prod_valid(pv[1]), .prod_ready(pr[1]), .prod_data(pd[1]), .prod_last(pl[1]),
        .acc_valid(av[1]), .acc_ready(ar[1]),
        .acc_data(ad1), .acc_count(ac1), .acc_ovf(ao[1])
    );

    approx_mul_accumulator #(.ACC_W(17), .MAX_TERMS(256), .SAT(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n),
        .prod_valid(pv[2]), .prod_ready(pr[2]), .prod_data(pd[2]), .prod_last(pl[2]),
        .acc_valid(av[2]), .acc_ready(ar[2]),
        .acc_data(ad2), .acc_count(ac2), .acc_ovf(ao[2])
    );

    approx_mul_accumulator #(.ACC_W(24), .MAX_TERMS(4), .SAT(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n),
        .prod_valid(pv[3]), .prod_ready(pr[3]), .prod_data(pd[3]), .prod_last(pl[3]),
        .acc_valid(av[3]), .acc_ready(ar[3]),
        .acc_data(ad3), .acc_count(ac3), .acc_ovf(ao[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int aw(input int k);
        return (k == 1 || k == 2) ? 17 : 24;
    endfunction

    function automatic int mt(input int k);
        return (k == 3) ? 4 : 256;
    endfunction

    function automatic bit st(input int k);
        return (k == 2) ? 1'b0 : 1'b1;
    endfunction

    function automatic res_t rd(input int k);
        res_t r;
        case (k)
            0:       begin r.d = ad0;          r.c = ac0;          r.o = ao[0]; end
            1:       begin r.d = {7'd0, ad1};  r.c = ac1;          r.o = ao[1]; end
            2:       begin r.d = {7'd0, ad2};  r.c = ac2;          r.o = ao[2]; end
            default: begin r.d = ad3;          r.c = {6'd0, ac3};  r.o = ao[3]; end
        endcase
        return r;
    endfunction

    function automatic res_t pop_exp();
        res_t r;
        r = 'x;
        if (q.size() != 0) r = q.pop_front();
        return r;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            msum[k] = 0;
            mcnt[k] = 0;
            movf[k] = 1'b0;
        end
        q.delete();
    endtask

    task automatic model_accept(input int k, input int d, input bit last);
        longint lim;
        res_t   r;
        lim = longint'(1) << aw(k);
        msum[k] += d;
        mcnt[k]++;
        if (msum[k] >= lim) begin
            movf[k] = 1'b1;
            msum[k] = st(k) ? lim - 1 : msum[k] - lim;
        end
        if (last || mcnt[k] == mt(k)) begin
            r.d = 24'(msum[k]);
            r.c = 9'(mcnt[k]);
            r.o = movf[k];
            q.push_back(r);
            msum[k] = 0;
            mcnt[k] = 0;
            movf[k] = 1'b0;
        end
    endtask

    // Present a beat from the next negedge until an edge accepts it.
    task automatic send(input int k, input int d, input bit last);
        int n;
        n = 0;
        @(negedge clk);
        pv[k] = 1'b1;
        pd[k] = 16'(d);
        pl[k] = last;
        while (!pr[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!pr[k]) begin
            checks++;
            errors++;
            $display("FAIL send_timeout inst %0d ready %0b exp 1", k, pr[k]);
            pv[k] = 1'b0;
        end else begin
            model_accept(k, d, last);
            @(posedge clk);
        end
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        pv[k] = 1'b0;
        pl[k] = 1'b0;
    endtask

    task automatic grab(input int k, input int hold, output res_t got, output bit ok);
        int n;
        n   = 0;
        ok  = 1'b0;
        got = 'x;
        ar[k] = 1'b0;
        @(negedge clk);
        while (!av[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (av[k]) begin
            got = rd(k);
            repeat (hold) @(negedge clk);
            ar[k] = 1'b1;
            @(negedge clk);
            ar[k] = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        res_t r;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        r = rd(0);
        checks++;
        if (av[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %0b exp 0", av[0]);
        end
        checks++;
        if (r.d !== 24'd0 || r.c !== 9'd0 || r.o !== 1'b0) begin
            errors++;
            $display("FAIL rst_outputs got %0d/%0d/%0b exp 0/0/0", r.d, r.c, r.o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pr[0] !== 1'b1 || pr[3] !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got %0b%0b exp 11", pr[0], pr[3]);
        end
    endtask

    task automatic test_basic();
        res_t got, e;
        bit   ok;
        send(0, 16'hFE01, 1'b0);
        send(0, 16'hFE01, 1'b0);
        send(0, 16'hFE01, 1'b1);
        checks++;
        if (av[0] !== 1'b0) begin
            errors++;
            $display("FAIL t1_early_valid got %0b exp 0", av[0]);
        end
        idle(0);
        checks++;
        if (av[0] !== 1'b1) begin
            errors++;
            $display("FAIL t1_latency got %0b exp 1", av[0]);
        end
        grab(0, 0, got, ok);
        e = pop_exp();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL t1_sb got %0d/%0d/%0b exp %0d/%0d/%0b", got.d, got.c, got.o, e.d, e.c, e.o);
        end
        checks++;
        if (got.d !== 24'd195075 || got.c !== 9'd3 || got.o !== 1'b0) begin
            errors++;
            $display("FAIL t1_const got %0d/%0d/%0b exp 195075/3/0", got.d, got.c, got.o);
        end
        checks++;
        if (av[0] !== 1'b0 || pr[0] !== 1'b1) begin
            errors++;
            $display("FAIL t1_release got v%0b r%0b exp v0 r1", av[0], pr[0]);
        end
    endtask

    task automatic test_overflow();
        res_t got, e;
        bit   ok;
        for (int k = 1; k <= 2; k++) begin
            send(k, 16'hFE01, 1'b0);
            send(k, 16'hFE01, 1'b0);
            send(k, 16'hFE01, 1'b1);
            idle(k);
            grab(k, 0, got, ok);
            e = pop_exp();
            checks++;
            if (!ok || got !== e) begin
                errors++;
                $display("FAIL t2_sb inst %0d got %0d/%0d/%0b exp %0d/%0d/%0b",
                         k, got.d, got.c, got.o, e.d, e.c, e.o);
            end
            checks++;
            if (got.d !== ((k == 1) ? 24'd131071 : 24'd64003) || got.o !== 1'b1) begin
                errors++;
                $display("FAIL t2_const inst %0d got %0d/%0b exp %0d/1",
                         k, got.d, got.o, (k == 1) ? 131071 : 64003);
            end
        end
        send(1, 16'hFE01, 1'b0);
        send(1, 16'hFE01, 1'b0);
        send(1, 16'hFE01, 1'b0);
        send(1, 5, 1'b1);
        idle(1);
        grab(1, 0, got, ok);
        e = pop_exp();
        checks++;
        if (!ok || got !== e || got.d !== 24'd131071 || got.c !== 9'd4) begin
            errors++;
            $display("FAIL t2_sticky got %0d/%0d/%0b exp 131071/4/1", got.d, got.c, got.o);
        end
    endtask

    task automatic test_max_terms();
        res_t got, got2, e;
        bit   ok, ok2;
        for (int i = 0; i < 4; i++) send(3, 1, 1'b0);
        fork
            send(3, 1, 1'b0);
            grab(3, 2, got, ok);
        join
        e = pop_exp();
        checks++;
        if (!ok || got !== e || got.d !== 24'd4 || got.c !== 9'd4 || got.o !== 1'b0) begin
            errors++;
            $display("FAIL t3_frame1 got %0d/%0d/%0b exp 4/4/0", got.d, got.c, got.o);
        end
        send(3, 0, 1'b1);
        idle(3);
        grab(3, 0, got, ok);
        e = pop_exp();
        checks++;
        if (!ok || got !== e || got.d !== 24'd1 || got.c !== 9'd2) begin
            errors++;
            $display("FAIL t3_frame2 got %0d/%0d/%0b exp 1/2/0", got.d, got.c, got.o);
        end
        for (int i = 0; i < 4; i++) send(3, 2, 1'b0);
        fork
            send(3, 9, 1'b1);
            grab(3, 0, got, ok);
        join
        idle(3);
        grab(3, 0, got2, ok2);
        e = pop_exp();
        checks++;
        if (!ok || got !== e || got.d !== 24'd8 || got.c !== 9'd4) begin
            errors++;
            $display("FAIL t3_force got %0d/%0d/%0b exp 8/4/0", got.d, got.c, got.o);
        end
        e = pop_exp();
        checks++;
        if (!ok2 || got2 !== e || got2.d !== 24'd9 || got2.c !== 9'd1) begin
            errors++;
            $display("FAIL t3_sole got %0d/%0d/%0b exp 9/1/0", got2.d, got2.c, got2.o);
        end
    endtask

    task automatic test_hold();
        res_t snap, cur, got, e;
        bit   ok;
        int   bad;
        send(0, 10, 1'b0);
        send(0, 20, 1'b1);
        idle(0);
        snap = rd(0);
        e = pop_exp();
        checks++;
        if (av[0] !== 1'b1 || snap !== e) begin
            errors++;
            $display("FAIL t4_first got %0d/%0d/%0b exp %0d/%0d/%0b",
                     snap.d, snap.c, snap.o, e.d, e.c, e.o);
        end
        bad = 0;
        fork
            send(0, 30, 1'b1);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    cur = rd(0);
                    if (av[0] !== 1'b1 || pr[0] !== 1'b0 || cur !== snap) bad++;
                end
                ar[0] = 1'b1;
                @(negedge clk);
                ar[0] = 1'b0;
                checks++;
                if (av[0] !== 1'b0 || pr[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL t4_release got v%0b r%0b exp v0 r1", av[0], pr[0]);
                end
            end
        join
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL t4_stable got %0d unstable cycles exp 0", bad);
        end
        idle(0);
        grab(0, 0, got, ok);
        e = pop_exp();
        checks++;
        if (!ok || got !== e || got.d !== 24'd30 || got.c !== 9'd1) begin
            errors++;
            $display("FAIL t4_held_beat got %0d/%0d/%0b exp 30/1/0", got.d, got.c, got.o);
        end
    endtask

    task automatic test_reset_mid();
        res_t got, e;
        bit   ok;
        send(0, 9, 1'b1);
        idle(0);
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        checks++;
        if (av[0] !== 1'b0) begin
            errors++;
            $display("FAIL t5_async_hold got %0b exp 0", av[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 5, 1'b0);
        send(0, 6, 1'b0);
        idle(0);
        #2;
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (av[0] !== 1'b0 || pr[0] !== 1'b1) begin
            errors++;
            $display("FAIL t5_discard got v%0b r%0b exp v0 r1", av[0], pr[0]);
        end
        send(0, 7, 1'b1);
        idle(0);
        grab(0, 0, got, ok);
        e = pop_exp();
        checks++;
        if (!ok || got !== e || got.d !== 24'd7 || got.c !== 9'd1 || got.o !== 1'b0) begin
            errors++;
            $display("FAIL t5_after got %0d/%0d/%0b exp 7/1/0", got.d, got.c, got.o);
        end
    endtask

    task automatic test_zero();
        res_t got, e;
        bit   ok;
        send(0, 0, 1'b1);
        idle(0);
        grab(0, 0, got, ok);
        e = pop_exp();
        checks++;
        if (!ok || got !== e || got.d !== 24'd0 || got.c !== 9'd1 || got.o !== 1'b0) begin
            errors++;
            $display("FAIL t6_zero got %0d/%0d/%0b exp 0/1/0", got.d, got.c, got.o);
        end
    endtask

    task automatic test_back_to_back();
        int dat [40];
        bit lst [40];
        int nf;
        nf = 0;
        for (int i = 0; i < 40; i++) begin
            dat[i] = int'($urandom_range(0, 65535));
            lst[i] = (i == 39) || ($urandom_range(0, 3) == 0);
            if (lst[i]) nf++;
        end
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(0);
                    send(0, dat[i], lst[i]);
                end
                idle(0);
            end
            begin
                res_t got, e;
                int   n;
                for (int f = 0; f < nf; f++) begin
                    n = 0;
                    @(negedge clk);
                    while (!av[0] && n < 2000) begin
                        @(negedge clk);
                        n++;
                    end
                    checks++;
                    if (!av[0]) begin
                        errors++;
                        $display("FAIL t6_timeout frame %0d valid %0b exp 1", f, av[0]);
                        break;
                    end
                    got = rd(0);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    ar[0] = 1'b1;
                    @(negedge clk);
                    ar[0] = 1'b0;
                    e = pop_exp();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL t6_frame %0d got %0d/%0d/%0b exp %0d/%0d/%0b",
                                 f, got.d, got.c, got.o, e.d, e.c, e.o);
                    end
                end
            end
        join
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pv[k] = 1'b0;
            pl[k] = 1'b0;
            pd[k] = 16'd0;
            ar[k] = 1'b0;
        end
        clear_model();
        test_reset();
        test_basic();
        test_overflow();
        test_max_terms();
        test_hold();
        test_reset_mid();
        test_zero();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time %0t exp finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
